// File: rtl/exec_operand_wb.sv
// exec_operand_wb -- execute stage wrapped around an external 12-bit combinational ALU.
//
// Holds the general register file and the architectural flags register {V,K,S,Z}.
// An accepted instruction has its operands captured into a one-deep execute latch,
// which drives the ALU. On the following rising edge the ALU result and flags are
// written back. A separate load port writes registers from memory.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   in_valid/in_ready   decode handshake (in_ready drops whenever a load is presented)
//   in_op/rd/rs         operation, destination (also operand A), operand B register
//   in_imm_en/in_imm    select and value of the immediate operand B
//   in_wb_en            1: write result to rd; 0: update flags only
//   alu_a/b/op/flg      execute latch and flags register driven to the ALU
//   alu_q/alu_flg_q     ALU result and flags
//   ld_en/addr/data     register write from the load path
//   dbg_addr/dbg_data   combinational register read, no forwarding
//   flags               architectural flags register
//   busy                execute latch holds a valid operation
module exec_operand_wb #(
    parameter int NREG   = 8,
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [REG_AW-1:0] in_rs,
    input  logic              in_imm_en,
    input  logic [11:0]       in_imm,
    input  logic              in_wb_en,
    output logic [11:0]       alu_a,
    output logic [11:0]       alu_b,
    output logic [3:0]        alu_op,
    output logic [3:0]        alu_flg,
    input  logic [11:0]       alu_q,
    input  logic [3:0]        alu_flg_q,
    input  logic              ld_en,
    input  logic [REG_AW-1:0] ld_addr,
    input  logic [11:0]       ld_data,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [11:0]       dbg_data,
    output logic [3:0]        flags,
    output logic              busy
);

    logic [11:0]       regs_q [NREG];
    logic [11:0]       regs_d [NREG];
    logic [3:0]        flags_q, flags_d;
    logic              ex_valid_q, ex_valid_d;
    logic              ex_wb_en_q, ex_wb_en_d;
    logic [REG_AW-1:0] ex_rd_q, ex_rd_d;
    logic [3:0]        ex_op_q, ex_op_d;
    logic [11:0]       ex_a_q, ex_a_d;
    logic [11:0]       ex_b_q, ex_b_d;

    logic              issue_s;
    logic              wb_fire_s;
    logic              fwd_hit_rd_s;
    logic              fwd_hit_rs_s;
    logic [11:0]       fwd_a_s;
    logic [11:0]       fwd_b_s;

    // The load port owns the register write side for its cycle, so decode is stalled.
    assign in_ready  = ~ld_en;
    assign issue_s   = in_valid & ~ld_en;
    assign wb_fire_s = ex_valid_q & ex_wb_en_q;

    assign alu_a    = ex_a_q;
    assign alu_b    = ex_b_q;
    assign alu_op   = ex_op_q;
    assign alu_flg  = flags_q;
    assign flags    = flags_q;
    assign busy     = ex_valid_q;
    assign dbg_data = regs_q[dbg_addr];

    // Operand forwarding: a register being written back this edge is read from alu_q.
    always_comb begin
        fwd_hit_rd_s = wb_fire_s & (ex_rd_q == in_rd);
        fwd_hit_rs_s = wb_fire_s & (ex_rd_q == in_rs);
        if (fwd_hit_rd_s) begin
            fwd_a_s = alu_q;
        end else begin
            fwd_a_s = regs_q[in_rd];
        end
        if (in_imm_en) begin
            fwd_b_s = in_imm;
        end else if (fwd_hit_rs_s) begin
            fwd_b_s = alu_q;
        end else begin
            fwd_b_s = regs_q[in_rs];
        end
    end

    // Execute latch next state: capture on issue, otherwise hold operands and go idle.
    always_comb begin
        ex_valid_d = issue_s;
        if (issue_s) begin
            ex_wb_en_d = in_wb_en;
            ex_rd_d    = in_rd;
            ex_op_d    = in_op;
            ex_a_d     = fwd_a_s;
            ex_b_d     = fwd_b_s;
        end else begin
            ex_wb_en_d = ex_wb_en_q;
            ex_rd_d    = ex_rd_q;
            ex_op_d    = ex_op_q;
            ex_a_d     = ex_a_q;
            ex_b_d     = ex_b_q;
        end
    end

    // Register file and flags next state; an ALU writeback beats a load to the same register.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            if (wb_fire_s && (ex_rd_q == REG_AW'(i))) begin
                regs_d[i] = alu_q;
            end else if (ld_en && (ld_addr == REG_AW'(i))) begin
                regs_d[i] = ld_data;
            end else begin
                regs_d[i] = regs_q[i];
            end
        end
        if (ex_valid_q) begin
            flags_d = alu_flg_q;
        end else begin
            flags_d = flags_q;
        end
    end

    // State registers; reset discards any in-flight operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= 12'h000;
            end
            flags_q    <= 4'h0;
            ex_valid_q <= 1'b0;
            ex_wb_en_q <= 1'b0;
            ex_rd_q    <= '0;
            ex_op_q    <= 4'h0;
            ex_a_q     <= 12'h000;
            ex_b_q     <= 12'h000;
        end else begin
            regs_q     <= regs_d;
            flags_q    <= flags_d;
            ex_valid_q <= ex_valid_d;
            ex_wb_en_q <= ex_wb_en_d;
            ex_rd_q    <= ex_rd_d;
            ex_op_q    <= ex_op_d;
            ex_a_q     <= ex_a_d;
            ex_b_q     <= ex_b_d;
        end
    end

endmodule

// File: tb/tb_exec_operand_wb.sv
// tb_exec_operand_wb -- bench for exec_operand_wb.
// Provides a small combinational ALU (0 MOV, 1 ADD, 2 ADK, 3 SUB, 4 AND, 5 OR, 6 XOR, F ASR)
// and an in-order architectural model: each issued op is evaluated against the model
// register file/flags and queued; the queue is drained at the DUT writeback edge.
module tb_exec_operand_wb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_op = 4'h0;
    logic [2:0]  in_rd = 3'd0;
    logic [2:0]  in_rs = 3'd0;
    logic        in_imm_en = 1'b0;
    logic [11:0] in_imm = 12'h000;
    logic        in_wb_en = 1'b0;
    logic [11:0] alu_a, alu_b, alu_q;
    logic [3:0]  alu_op, alu_flg, alu_flg_q;
    logic        ld_en = 1'b0;
    logic [2:0]  ld_addr = 3'd0;
    logic [11:0] ld_data = 12'h000;
    logic [2:0]  dbg_addr = 3'd0;
    logic [11:0] dbg_data;
    logic [3:0]  flags;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        valid;
        logic [3:0]  op;
        logic [2:0]  rd;
        logic [2:0]  rs;
        logic        imm_en;
        logic [11:0] imm;
        logic        wb;
        logic        ld;
        logic [2:0]  ld_addr;
        logic [11:0] ld_data;
        logic        exp_ready;
    } vec_t;

    typedef struct {
        logic [2:0]  rd;
        logic        wb;
        logic [3:0]  op;
        logic [11:0] a;
        logic [11:0] b;
        logic [11:0] q;
        logic [3:0]  flg;
    } sb_t;

    sb_t         q_sb[$];
    logic [11:0] ref_regs [8];
    logic [3:0]  ref_flags;
    logic        pend;

    exec_operand_wb #(.NREG(8), .REG_AW(3)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rd(in_rd), .in_rs(in_rs), .in_imm_en(in_imm_en), .in_imm(in_imm),
        .in_wb_en(in_wb_en),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_flg(alu_flg),
        .alu_q(alu_q), .alu_flg_q(alu_flg_q),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .flags(flags), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference ALU: returns {V,K,S,Z,q}.
    function automatic logic [15:0] alu_fn(input logic [3:0] op, input logic [11:0] a,
                                           input logic [11:0] b, input logic [3:0] fi);
        logic [12:0] s;
        logic [11:0] q;
        logic        v, k;
        v = fi[3];
        k = fi[2];
        s = 13'h0000;
        case (op)
            4'h0: q = b;
            4'h1: begin
                s = {1'b0, a} + {1'b0, b};
                q = s[11:0];
                k = s[12];
                v = (a[11] == b[11]) && (q[11] != a[11]);
            end
            4'h2: begin
                s = {1'b0, a} + {1'b0, b} + {12'h000, fi[2]};
                q = s[11:0];
                k = s[12];
                v = (a[11] == b[11]) && (q[11] != a[11]);
            end
            4'h3: begin
                s = {1'b0, a} - {1'b0, b};
                q = s[11:0];
                k = s[12];
                v = (a[11] != b[11]) && (q[11] != a[11]);
            end
            4'h4: q = a & b;
            4'h5: q = a | b;
            4'h6: q = a ^ b;
            4'hF: q = {a[11], a[11:1]};
            default: q = a;
        endcase
        return {v, k, q[11], (q == 12'h000), q};
    endfunction

    always_comb {alu_flg_q, alu_q} = alu_fn(alu_op, alu_a, alu_b, alu_flg);

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%03h expected 0x%03h", name, act, exp);
        end
    endtask

    task automatic rd_reg(input logic [2:0] a, output logic [11:0] d);
        dbg_addr = a;
        #1;
        d = dbg_data;
    endtask

    function automatic vec_t mkv(input logic valid, input logic [3:0] op, input logic [2:0] rd,
                                 input logic [2:0] rs, input logic imm_en, input logic [11:0] imm,
                                 input logic wb, input logic ld, input logic [2:0] la,
                                 input logic [11:0] ldd);
        vec_t v;
        v = '{valid, op, rd, rs, imm_en, imm, wb, ld, la, ldd, ~ld};
        return v;
    endfunction

    // One clock cycle: drive, check pre-edge, update model at the edge, check writeback.
    task automatic cycle(input vec_t v);
        sb_t         it;
        sb_t         wb_it;
        logic        wb_valid;
        logic        issue;
        logic [11:0] a, b, d;
        logic [15:0] r;
        in_valid  = v.valid;
        in_op     = v.op;
        in_rd     = v.rd;
        in_rs     = v.rs;
        in_imm_en = v.imm_en;
        in_imm    = v.imm;
        in_wb_en  = v.wb;
        ld_en     = v.ld;
        ld_addr   = v.ld_addr;
        ld_data   = v.ld_data;
        #1;
        chk("in_ready", {11'h000, in_ready}, {11'h000, v.exp_ready});
        if (pend) begin
            if (q_sb.size() == 0) begin
                chk("sb_empty", 12'h001, 12'h000);
            end else begin
                chk("alu_a", alu_a, q_sb[0].a);
                chk("alu_b", alu_b, q_sb[0].b);
                chk("alu_op", {8'h00, alu_op}, {8'h00, q_sb[0].op});
            end
        end
        issue = v.valid && !v.ld;
        @(posedge clk);
        wb_valid = 1'b0;
        if (pend && q_sb.size() != 0) begin
            wb_it = q_sb.pop_front();
            wb_valid = 1'b1;
        end
        if (v.ld && !(wb_valid && wb_it.wb && wb_it.rd == v.ld_addr))
            ref_regs[v.ld_addr] = v.ld_data;
        if (wb_valid) begin
            ref_flags = wb_it.flg;
            if (wb_it.wb) ref_regs[wb_it.rd] = wb_it.q;
        end
        if (issue) begin
            a = ref_regs[v.rd];
            b = v.imm_en ? v.imm : ref_regs[v.rs];
            r = alu_fn(v.op, a, b, ref_flags);
            it = '{v.rd, v.wb, v.op, a, b, r[11:0], r[15:12]};
            q_sb.push_back(it);
        end
        pend = issue;
        #1;
        chk("busy", {11'h000, busy}, {11'h000, issue});
        chk("flags", {8'h00, flags}, {8'h00, ref_flags});
        if (wb_valid) begin
            rd_reg(wb_it.rd, d);
            chk("wb_reg", d, ref_regs[wb_it.rd]);
        end
        if (v.ld) begin
            rd_reg(v.ld_addr, d);
            chk("ld_reg", d, ref_regs[v.ld_addr]);
        end
    endtask

    task automatic do_reset();
        logic [11:0] d;
        rst = 1'b1;
        in_valid = 1'b0;
        ld_en = 1'b0;
        q_sb.delete();
        for (int i = 0; i < 8; i++) ref_regs[i] = 12'h000;
        ref_flags = 4'h0;
        pend = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_busy", {11'h000, busy}, 12'h000);
        chk("rst_flags", {8'h00, flags}, 12'h000);
        chk("rst_alu_a", alu_a, 12'h000);
        chk("rst_alu_b", alu_b, 12'h000);
        chk("rst_alu_op", {8'h00, alu_op}, 12'h000);
        for (int i = 0; i < 8; i++) begin
            rd_reg(3'(i), d);
            chk("rst_reg", d, 12'h000);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    vec_t        tbl [16];
    vec_t        idle;
    vec_t        rv;
    logic [3:0]  op_list [8];
    logic [11:0] d;

    initial begin
        tbl[0]  = '{1'b0, 4'h0, 3'd0, 3'd0, 1'b0, 12'h000, 1'b0, 1'b1, 3'd0, 12'h800, 1'b0};
        tbl[1]  = '{1'b0, 4'h0, 3'd0, 3'd0, 1'b0, 12'h000, 1'b0, 1'b1, 3'd1, 12'h7FF, 1'b0};
        tbl[2]  = '{1'b1, 4'h1, 3'd1, 3'd0, 1'b0, 12'h000, 1'b1, 1'b0, 3'd0, 12'h000, 1'b1};
        tbl[3]  = '{1'b1, 4'h3, 3'd0, 3'd1, 1'b0, 12'h000, 1'b1, 1'b0, 3'd0, 12'h000, 1'b1};
        tbl[4]  = '{1'b1, 4'h1, 3'd0, 3'd0, 1'b1, 12'h800, 1'b1, 1'b0, 3'd0, 12'h000, 1'b1};
        tbl[5]  = '{1'b1, 4'h4, 3'd2, 3'd0, 1'b1, 12'hF0F, 1'b1, 1'b0, 3'd0, 12'h000, 1'b1};
        tbl[6]  = '{1'b1, 4'h5, 3'd2, 3'd1, 1'b0, 12'h000, 1'b1, 1'b0, 3'd0, 12'h000, 1'b1};
        tbl[7]  = '{1'b1, 4'h6, 3'd2, 3'd2, 1'b0, 12'h000, 1'b0, 1'b0, 3'd0, 12'h000, 1'b1};
        tbl[8]  = '{1'b1, 4'h1, 3'd3, 3'd0, 1'b1, 12'h001, 1'b1, 1'b1, 3'd3, 12'hABC, 1'b0};
        tbl[9]  = '{1'b1, 4'hF, 3'd3, 3'd0, 1'b0, 12'h000, 1'b1, 1'b0, 3'd0, 12'h000, 1'b1};
        tbl[10] = '{1'b1, 4'hF, 3'd3, 3'd0, 1'b0, 12'h000, 1'b1, 1'b0, 3'd0, 12'h000, 1'b1};
        tbl[11] = '{1'b1, 4'h0, 3'd4, 3'd3, 1'b0, 12'h000, 1'b1, 1'b0, 3'd0, 12'h000, 1'b1};
        tbl[12] = '{1'b0, 4'h0, 3'd0, 3'd0, 1'b0, 12'h000, 1'b0, 1'b0, 3'd0, 12'h000, 1'b1};
        tbl[13] = '{1'b1, 4'h2, 3'd5, 3'd0, 1'b1, 12'hFFF, 1'b1, 1'b0, 3'd0, 12'h000, 1'b1};
        tbl[14] = '{1'b1, 4'h3, 3'd5, 3'd0, 1'b1, 12'h001, 1'b1, 1'b0, 3'd0, 12'h000, 1'b1};
        tbl[15] = '{1'b0, 4'h0, 3'd0, 3'd0, 1'b0, 12'h000, 1'b0, 1'b1, 3'd6, 12'h5A5, 1'b0};
        op_list = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hF};
        idle = mkv(1'b0, 4'h0, 3'd0, 3'd0, 1'b0, 12'h000, 1'b0, 1'b0, 3'd0, 12'h000);

        do_reset();

        // MOV r1,#0x123
        cycle(mkv(1'b1, 4'h0, 3'd1, 3'd0, 1'b1, 12'h123, 1'b1, 1'b0, 3'd0, 12'h000));
        cycle(idle);
        rd_reg(3'd1, d);
        chk("t1_r1", d, 12'h123);
        chk("t1_flags", {8'h00, flags}, 12'h000);

        // r1=0xFFF; ADD r1,#1; ADK r2,#0 back-to-back
        cycle(mkv(1'b0, 4'h0, 3'd0, 3'd0, 1'b0, 12'h000, 1'b0, 1'b1, 3'd1, 12'hFFF));
        cycle(mkv(1'b1, 4'h1, 3'd1, 3'd0, 1'b1, 12'h001, 1'b1, 1'b0, 3'd0, 12'h000));
        cycle(mkv(1'b1, 4'h2, 3'd2, 3'd0, 1'b1, 12'h000, 1'b1, 1'b0, 3'd0, 12'h000));
        chk("t2_add_flags", {8'h00, flags}, 12'h005);
        cycle(idle);
        rd_reg(3'd1, d);
        chk("t2_r1", d, 12'h000);
        rd_reg(3'd2, d);
        chk("t2_r2", d, 12'h001);

        // ADD r3,#5 three times, dependent through forwarding
        cycle(mkv(1'b1, 4'h1, 3'd3, 3'd0, 1'b1, 12'h005, 1'b1, 1'b0, 3'd0, 12'h000));
        chk("t3_a0", alu_a, 12'h000);
        cycle(mkv(1'b1, 4'h1, 3'd3, 3'd0, 1'b1, 12'h005, 1'b1, 1'b0, 3'd0, 12'h000));
        chk("t3_a1", alu_a, 12'h005);
        cycle(mkv(1'b1, 4'h1, 3'd3, 3'd0, 1'b1, 12'h005, 1'b1, 1'b0, 3'd0, 12'h000));
        chk("t3_a2", alu_a, 12'h00A);
        cycle(idle);
        rd_reg(3'd3, d);
        chk("t3_r3", d, 12'h00F);

        // compare SUB r4,r4 without writeback
        cycle(mkv(1'b0, 4'h0, 3'd0, 3'd0, 1'b0, 12'h000, 1'b0, 1'b1, 3'd4, 12'h456));
        cycle(mkv(1'b1, 4'h3, 3'd4, 3'd4, 1'b0, 12'h000, 1'b0, 1'b0, 3'd0, 12'h000));
        cycle(idle);
        rd_reg(3'd4, d);
        chk("t4_r4", d, 12'h456);
        chk("t4_flags", {8'h00, flags}, 12'h001);

        // load blocks issue; load colliding with writeback is dropped; disjoint both write
        cycle(mkv(1'b1, 4'h0, 3'd7, 3'd0, 1'b1, 12'h999, 1'b1, 1'b1, 3'd6, 12'h222));
        chk("t5_no_issue", {11'h000, busy}, 12'h000);
        cycle(mkv(1'b1, 4'h0, 3'd5, 3'd0, 1'b1, 12'h777, 1'b1, 1'b0, 3'd0, 12'h000));
        cycle(mkv(1'b0, 4'h0, 3'd0, 3'd0, 1'b0, 12'h000, 1'b0, 1'b1, 3'd5, 12'h111));
        rd_reg(3'd5, d);
        chk("t5_r5_wins", d, 12'h777);
        cycle(mkv(1'b1, 4'h0, 3'd5, 3'd0, 1'b1, 12'h0AB, 1'b1, 1'b0, 3'd0, 12'h000));
        cycle(mkv(1'b0, 4'h0, 3'd0, 3'd0, 1'b0, 12'h000, 1'b0, 1'b1, 3'd6, 12'h333));
        rd_reg(3'd5, d);
        chk("t5_r5", d, 12'h0AB);
        rd_reg(3'd6, d);
        chk("t5_r6", d, 12'h333);
        rd_reg(3'd7, d);
        chk("t5_r7", d, 12'h000);

        // table-driven vectors
        for (int i = 0; i < 16; i++) cycle(tbl[i]);

        // randomized traffic through the same model
        for (int i = 0; i < 400; i++) begin
            rv = mkv(1'($urandom_range(0, 1)), op_list[$urandom_range(0, 7)],
                     3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                     1'($urandom_range(0, 1)), 12'($urandom_range(0, 4095)),
                     1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
                     3'($urandom_range(0, 7)), 12'($urandom_range(0, 4095)));
            cycle(rv);
        end
        cycle(idle);

        // reset while an op is in flight
        cycle(mkv(1'b1, 4'h0, 3'd7, 3'd0, 1'b1, 12'h5A5, 1'b1, 1'b0, 3'd0, 12'h000));
        chk("t6_busy_pre", {11'h000, busy}, 12'h001);
        rst = 1'b1;
        #1;
        chk("t6_busy_async", {11'h000, busy}, 12'h000);
        do_reset();
        rd_reg(3'd7, d);
        chk("t6_r7", d, 12'h000);
        chk("t6_flags", {8'h00, flags}, 12'h000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
